// File: rtl/mri_exec_unit.sv
// PDP-8 style memory-reference instruction engine (AND/TAD/ISZ/DCA/JMS/JMP)
// with direct, indirect and auto-increment addressing over a req/ack memory port.
module mri_exec_unit #(
    parameter int WIDTH         = 12,
    parameter int AUTOINC_BASE  = 8,
    parameter int AUTOINC_COUNT = 8
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             start,
    input  logic [WIDTH-1:0] instr,
    input  logic [WIDTH-1:0] ac_in,
    input  logic             lk_in,
    input  logic [WIDTH-1:0] pc_in,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] ac_out,
    output logic             lk_out,
    output logic [WIDTH-1:0] pc_out
);

    typedef enum logic [2:0] {
        S_IDLE, S_IND_RD, S_IND_WB, S_OP_RD, S_OP_WB, S_DONE
    } state_t;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_TAD = 3'd1;
    localparam logic [2:0] OP_ISZ = 3'd2;
    localparam logic [2:0] OP_DCA = 3'd3;
    localparam logic [2:0] OP_JMS = 3'd4;
    localparam logic [2:0] OP_JMP = 3'd5;

    localparam logic [WIDTH-1:0] AI_LO = WIDTH'(AUTOINC_BASE);
    localparam logic [WIDTH-1:0] AI_HI = WIDTH'(AUTOINC_BASE + AUTOINC_COUNT - 1);

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] ea_q, ea_d, ac_q, ac_d, pc_q, pc_d, npc_q, npc_d, data_q, data_d;
    logic             lk_q, lk_d, ill_q, ill_d;
    logic             req_q, req_d, we_q, we_d;
    logic [WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [WIDTH-1:0] ac_out_q, ac_out_d, pc_out_q, pc_out_d;
    logic             lk_out_q, lk_out_d;

    logic             launch;
    logic [WIDTH-1:0] ea_in, rdata_inc;
    logic [WIDTH:0]   tad_sum;
    logic             ea_autoinc;

    assign ea_in      = {instr[WIDTH-5] ? pc_in[WIDTH-1:WIDTH-5] : 5'b0, instr[WIDTH-6:0]};
    assign rdata_inc  = mem_rdata + 1'b1;
    assign tad_sum    = {1'b0, ac_q} + {1'b0, mem_rdata};
    assign ea_autoinc = (ea_q >= AI_LO) && (ea_q <= AI_HI);

    function automatic state_t op_state(input logic [2:0] op);
        case (op)
            OP_AND, OP_TAD, OP_ISZ: op_state = S_OP_RD;
            OP_DCA, OP_JMS:         op_state = S_OP_WB;
            default:                op_state = S_DONE;
        endcase
    endfunction

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d  = state_q;
        op_d     = op_q;
        ea_d     = ea_q;
        ac_d     = ac_q;
        lk_d     = lk_q;
        pc_d     = pc_q;
        npc_d    = npc_q;
        data_d   = data_q;
        ill_d    = ill_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        ac_out_d = ac_out_q;
        lk_out_d = lk_out_q;
        pc_out_d = pc_out_q;
        launch   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !busy_q) begin
                    op_d   = instr[WIDTH-1:WIDTH-3];
                    ea_d   = ea_in;
                    ac_d   = ac_in;
                    lk_d   = lk_in;
                    pc_d   = pc_in;
                    npc_d  = pc_in + 1'b1;
                    ill_d  = 1'b0;
                    busy_d = 1'b1;
                    if (op_d > OP_JMP) begin
                        ill_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (op_d == OP_JMP && !instr[WIDTH-4]) begin
                        npc_d   = ea_in;
                        state_d = S_DONE;
                    end else if (instr[WIDTH-4]) begin
                        state_d = S_IND_RD;
                        launch  = 1'b1;
                    end else begin
                        state_d = op_state(op_d);
                        launch  = 1'b1;
                    end
                end
            end
            S_IND_RD: begin
                if (!req_q) begin
                    launch = 1'b1;
                end else if (mem_ack) begin
                    req_d = 1'b0;
                    if (ea_autoinc) begin
                        data_d  = rdata_inc;
                        state_d = S_IND_WB;
                    end else begin
                        ea_d    = mem_rdata;
                        npc_d   = (op_q == OP_JMP) ? mem_rdata : npc_q;
                        state_d = op_state(op_q);
                    end
                end
            end
            S_IND_WB: begin
                if (!req_q) begin
                    launch = 1'b1;
                end else if (mem_ack) begin
                    req_d   = 1'b0;
                    ea_d    = data_q;
                    npc_d   = (op_q == OP_JMP) ? data_q : npc_q;
                    state_d = op_state(op_q);
                end
            end
            S_OP_RD: begin
                if (!req_q) begin
                    launch = 1'b1;
                end else if (mem_ack) begin
                    req_d   = 1'b0;
                    state_d = S_DONE;
                    case (op_q)
                        OP_AND: ac_d = ac_q & mem_rdata;
                        OP_TAD: begin
                            ac_d = tad_sum[WIDTH-1:0];
                            lk_d = lk_q ^ tad_sum[WIDTH];
                        end
                        OP_ISZ: begin
                            data_d  = rdata_inc;
                            state_d = S_OP_WB;
                        end
                        default: ;
                    endcase
                end
            end
            S_OP_WB: begin
                if (!req_q) begin
                    launch = 1'b1;
                end else if (mem_ack) begin
                    req_d   = 1'b0;
                    state_d = S_DONE;
                    case (op_q)
                        OP_ISZ: npc_d = (data_q == '0) ? pc_q + WIDTH'(2) : npc_q;
                        OP_DCA: ac_d  = '0;
                        OP_JMS: npc_d = ea_q + 1'b1;
                        default: ;
                    endcase
                end
            end
            S_DONE: begin
                done_d   = 1'b1;
                busy_d   = 1'b0;
                err_d    = ill_q;
                ac_out_d = ac_q;
                lk_out_d = lk_q;
                pc_out_d = npc_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Bus fields are loaded only when a request is raised, so they stay put while waiting for ack.
        if (launch) begin
            req_d   = 1'b1;
            addr_d  = ea_d;
            we_d    = (state_d == S_IND_WB) || (state_d == S_OP_WB);
            wdata_d = '0;
            if (state_d == S_IND_WB) begin
                wdata_d = data_d;
            end else if (state_d == S_OP_WB) begin
                case (op_d)
                    OP_ISZ:  wdata_d = data_d;
                    OP_DCA:  wdata_d = ac_d;
                    OP_JMS:  wdata_d = pc_d + 1'b1;
                    default: wdata_d = '0;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            ea_q     <= '0;
            ac_q     <= '0;
            lk_q     <= 1'b0;
            pc_q     <= '0;
            npc_q    <= '0;
            data_q   <= '0;
            ill_q    <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ac_out_q <= '0;
            lk_out_q <= 1'b0;
            pc_out_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            ea_q     <= ea_d;
            ac_q     <= ac_d;
            lk_q     <= lk_d;
            pc_q     <= pc_d;
            npc_q    <= npc_d;
            data_q   <= data_d;
            ill_q    <= ill_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            ac_out_q <= ac_out_d;
            lk_out_q <= lk_out_d;
            pc_out_q <= pc_out_d;
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign ac_out    = ac_out_q;
    assign lk_out    = lk_out_q;
    assign pc_out    = pc_out_q;

endmodule
